// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared types, sizes and opcode helpers for the matrix sequencer
package matrix_pkg;

  localparam int N      = 5;
  localparam int ELEM_W = 8;
  localparam int MAT_W  = 200;

  typedef enum logic [2:0] {
    OP_ADD       = 3'd0,
    OP_SUB       = 3'd1,
    OP_MUL       = 3'd2,
    OP_TRANSPOSE = 3'd3,
    OP_OPPOSITE  = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_EXEC   = 3'd3,
    ST_STORE  = 3'd4
  } state_e;

  function automatic logic op_needs_b(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_OPPOSITE;
  endfunction

endpackage

// File: rtl/matrix_elem_index.sv
// rtl/matrix_elem_index.sv - 0..24 element position counter as (row, col)
// col_major walks rows fastest so position p = 5c+r maps to element (r,c).
module matrix_elem_index
  import matrix_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic       col_major,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic       last
);

  localparam logic [2:0] MAX = 3'(N - 1);

  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;

  // Both walk orders end on (4,4), so one last flag serves both.
  assign last = (row_q == MAX) && (col_q == MAX);
  assign row  = row_q;
  assign col  = col_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr || (inc && last)) begin
      row_d = '0;
      col_d = '0;
    end else if (inc) begin
      if (col_major) begin
        if (row_q == MAX) begin
          row_d = '0;
          col_d = col_q + 3'd1;
        end else begin
          row_d = row_q + 3'd1;
        end
      end else begin
        if (col_q == MAX) begin
          col_d = '0;
          row_d = row_q + 3'd1;
        end else begin
          col_d = col_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/matrix_op_ctrl.sv
// rtl/matrix_op_ctrl.sv - 5x5 matrix coprocessor sequencer: load A/B, run ALU, stream result
// MATRIX_OP_CTRL_DIRECT_TRANSPOSE_EN: TRANSPOSE streams alu_a column-major, bypassing EXEC.
module matrix_op_ctrl
  import matrix_pkg::*;
#(
  parameter int ALU_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  input  logic [2:0]         cmd_op,
  output logic               cmd_ready,
  input  logic               in_valid,
  input  logic [ELEM_W-1:0]  in_data,
  output logic               in_ready,
  output logic [MAT_W-1:0]   alu_a,
  output logic [MAT_W-1:0]   alu_b,
  output logic [2:0]         alu_op,
  input  logic [MAT_W-1:0]   alu_result,
  output logic               out_valid,
  output logic [ELEM_W-1:0]  out_data,
  output logic               out_last,
  input  logic               out_ready,
  output logic               busy,
  output logic               err
);

  localparam logic [3:0] LAT_LAST = 4'(ALU_LATENCY - 1);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [MAT_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [3:0]       lat_q, lat_d;
  logic             err_q, err_d;

  logic             idx_clr, idx_inc, idx_last;
  logic             col_major, direct_xpose;
  logic [2:0]       row, col;
  logic [4:0]       elem_idx;
  logic [ELEM_W-1:0] store_elem;

`ifdef MATRIX_OP_CTRL_DIRECT_TRANSPOSE_EN
  assign direct_xpose = (op_q == OP_TRANSPOSE);
`else
  assign direct_xpose = 1'b0;
`endif

  assign col_major = direct_xpose && (state_q == ST_STORE);
  assign elem_idx  = 5'(int'(row) * N + int'(col));

  matrix_elem_index u_idx (
    .clk       (clk),
    .rst       (rst),
    .clr       (idx_clr),
    .inc       (idx_inc),
    .col_major (col_major),
    .row       (row),
    .col       (col),
    .last      (idx_last)
  );

  // Direct transpose reads the operand register itself; no result capture happens.
  assign store_elem = direct_xpose ? a_q[elem_idx*ELEM_W +: ELEM_W]
                                   : res_q[elem_idx*ELEM_W +: ELEM_W];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    lat_d   = lat_q;
    err_d   = 1'b0;
    idx_clr = 1'b0;
    idx_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          idx_clr = 1'b1;
          if (op_legal(cmd_op)) state_d = ST_LOAD_A;
          else                  err_d   = 1'b1;
        end
      end
      ST_LOAD_A: begin
        if (in_valid) begin
          a_d[elem_idx*ELEM_W +: ELEM_W] = in_data;
          idx_inc = 1'b1;
          if (idx_last) begin
            lat_d = '0;
            if (op_needs_b(op_q)) state_d = ST_LOAD_B;
            else if (direct_xpose) state_d = ST_STORE;
            else                   state_d = ST_EXEC;
          end
        end
      end
      ST_LOAD_B: begin
        if (in_valid) begin
          b_d[elem_idx*ELEM_W +: ELEM_W] = in_data;
          idx_inc = 1'b1;
          if (idx_last) begin
            lat_d   = '0;
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        lat_d = lat_q + 4'd1;
        if (lat_q == LAT_LAST) begin
          res_d   = alu_result;
          state_d = ST_STORE;
        end
      end
      ST_STORE: begin
        if (out_ready) begin
          idx_inc = 1'b1;
          if (idx_last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      lat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      lat_q   <= lat_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign in_ready  = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
  assign out_valid = (state_q == ST_STORE);
  assign out_data  = out_valid ? store_elem : '0;
  assign out_last  = out_valid && idx_last;
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;

endmodule

// File: tb/tb_matrix_op_ctrl.sv
// tb/tb_matrix_op_ctrl.sv - scoreboard bench for matrix_op_ctrl with a behavioural matrix model
module tb_matrix_op_ctrl;

  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic [2:0]   cmd_op;
  logic         cmd_ready;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic [199:0] alu_a, alu_b, alu_result;
  logic [2:0]   alu_op;
  logic         out_valid;
  logic [7:0]   out_data;
  logic         out_last;
  logic         out_ready;
  logic         busy;
  logic         err;

  matrix_op_ctrl #(.ALU_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int ma[25], mb[25], prev_b[25], stream[50];
  int exp_q[$];
  bit exp_last_q[$];
  int last_load_cyc = 0;
  int exp_lat = 0;
  bit lat_armed = 0;
  bit err_exp = 0;
  int rdy_mode = 0;

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Stand-in for the external combinational matrix ALU.
  function automatic logic [199:0] alu_fn(input logic [199:0] a, input logic [199:0] b,
                                          input logic [2:0] op);
    logic [199:0] r;
    logic [7:0] acc;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        case (op)
          3'd0: r[40*i+8*j +: 8] = a[40*i+8*j +: 8] + b[40*i+8*j +: 8];
          3'd1: r[40*i+8*j +: 8] = a[40*i+8*j +: 8] - b[40*i+8*j +: 8];
          3'd2: begin
            acc = '0;
            for (int m = 0; m < 5; m++) acc = acc + a[40*i+8*m +: 8] * b[40*m+8*j +: 8];
            r[40*i+8*j +: 8] = acc;
          end
          3'd3: r[40*i+8*j +: 8] = a[40*j+8*i +: 8];
          3'd4: r[40*i+8*j +: 8] = 8'd0 - a[40*i+8*j +: 8];
          default: r[40*i+8*j +: 8] = 8'd0;
        endcase
      end
    end
    return r;
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_op);

  // Reference: value of output position p for an op over matrices ma/mb.
  function automatic int ref_elem(input int op, input int p);
    int r, c, s;
    r = p / 5;
    c = p % 5;
    s = 0;
    case (op)
      0: return (ma[p] + mb[p]) & 255;
      1: return (ma[p] - mb[p]) & 255;
      2: begin
        for (int j = 0; j < 5; j++) s += ma[5*r+j] * mb[5*j+c];
        return s & 255;
      end
      3: return ma[5*c+r];
      default: return (256 - ma[p]) & 255;
    endcase
  endfunction

  function automatic logic [199:0] pack_prev_b();
    logic [199:0] v;
    for (int k = 0; k < 25; k++) v[8*k +: 8] = 8'(prev_b[k]);
    return v;
  endfunction

  initial begin
    int ph;
    ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = (ph == 0); ph = (ph + 1) % 3; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    bit pv, stall, fin, el;
    logic [7:0] sd;
    logic sl;
    int ev;
    pv = 0; stall = 0; fin = 0; sd = '0; sl = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0; stall = 0; fin = 0;
      end else begin
        if (fin) begin
          check_eq("cmd_ready_after_last", cmd_ready, 1);
          fin = 0;
        end
        if (err && !err_exp) check_eq("err_spurious", err, 0);
        if (stall) begin
          check_eq("stall_valid", out_valid, 1);
          check_eq("stall_data", out_data, sd);
          check_eq("stall_last", out_last, sl);
        end
        if (out_valid && !pv && lat_armed) begin
          check_eq("first_out_latency", cyc - last_load_cyc, exp_lat);
          lat_armed = 0;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("out_unexpected", out_data, -1);
          end else begin
            ev = exp_q.pop_front();
            el = exp_last_q.pop_front();
            check_eq("out_data", out_data, ev);
            check_eq("out_last", out_last, el);
            if (el) fin = 1;
          end
        end
        stall = out_valid && !out_ready;
        sd = out_data;
        sl = out_last;
        pv = out_valid;
      end
    end
  end

  task automatic start_cmd(input int op);
    cmd_valid = 1'b1;
    cmd_op = 3'(op);
    @(negedge clk);
    check_eq("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_op = 3'd7;
    @(negedge clk);
    check_eq("in_ready_after_cmd", in_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic feed(input int n, input bit bubbles, output int cycles);
    int k;
    k = 0;
    cycles = 0;
    while (k < n && cycles < 2000) begin
      in_valid = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data = 8'(stream[k]);
      @(negedge clk);
      cycles++;
      if (in_valid && in_ready) begin
        if (k == n - 1) last_load_cyc = cyc;
        k++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (k < n) check_eq("feed_timeout", k, n);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("drain_queue_empty", exp_q.size(), 0);
    check_eq("drain_idle", busy, 0);
  endtask

  task automatic run_op(input int op, input bit bubbles);
    int n, used;
    bit nb;
    nb = (op <= 2);
    n = nb ? 50 : 25;
    for (int k = 0; k < 25; k++) begin
      stream[k] = ma[k];
      stream[25+k] = mb[k];
    end
    start_cmd(op);
    feed(n, bubbles, used);
    cmd_valid = 1'b0;
    if (!bubbles) check_eq("load_full_rate", used, n);
    for (int p = 0; p < 25; p++) begin
      exp_q.push_back(ref_elem(op, p));
      exp_last_q.push_back(p == 24);
    end
`ifdef MATRIX_OP_CTRL_DIRECT_TRANSPOSE_EN
    exp_lat = (op == 3) ? 1 : LAT + 1;
`else
    exp_lat = LAT + 1;
`endif
    lat_armed = 1;
    if (nb) prev_b = mb;
    @(negedge clk);
    check_eq("in_ready_done", in_ready, 0);
    @(posedge clk); #1;
    drain();
  endtask

  task automatic rand_mats();
    for (int k = 0; k < 25; k++) begin
      ma[k] = $urandom_range(0, 255);
      mb[k] = $urandom_range(0, 255);
    end
  endtask

  initial begin
    int used;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; in_valid = 1'b0; in_data = '0;
    for (int k = 0; k < 25; k++) prev_b[k] = 0;
    repeat (2) @(posedge clk); #1;
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_alu_a_nz", int'(alu_a != '0), 0);
    check_eq("rst_alu_b_nz", int'(alu_b != '0), 0);
    check_eq("rst_alu_op", alu_op, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    rdy_mode = 0;
    for (int k = 0; k < 25; k++) ma[k] = k;
    run_op(3, 0);

    for (int k = 0; k < 25; k++) begin ma[k] = k; mb[k] = 1; end
    run_op(0, 0);

    rand_mats();
    rdy_mode = 1;
    run_op(2, 0);

    err_exp = 1;
    cmd_valid = 1'b1; cmd_op = 3'd6;
    @(negedge clk);
    check_eq("err_before", err, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("err_pulse", err, 1);
    check_eq("err_in_ready", in_ready, 0);
    check_eq("err_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("err_one_cycle", err, 0);
    err_exp = 0;
    @(posedge clk); #1;

    rdy_mode = 2;
    for (int i = 0; i < 4; i++) begin
      rand_mats();
      run_op($urandom_range(0, 4), 1);
    end

    rdy_mode = 0;
    rand_mats();
    run_op(4, 0);
    check_eq("opp_alu_b_kept", int'(alu_b == pack_prev_b()), 1);

    rand_mats();
    for (int k = 0; k < 25; k++) begin
      stream[k] = ma[k];
      stream[25+k] = mb[k];
    end
    start_cmd(1);
    feed(35, 0, used);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_in_ready", in_ready, 0);
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_alu_a_nz", int'(alu_a != '0), 0);
    check_eq("mid_rst_alu_b_nz", int'(alu_b != '0), 0);
    cmd_valid = 1'b0;
    for (int k = 0; k < 25; k++) prev_b[k] = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    rdy_mode = 2;
    rand_mats();
    run_op(0, 1);
    rand_mats();
    run_op(2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
